// File: rtl/window_fifo_gen.sv
// window_fifo_gen: sliding KxK window generator over a raster-order square
// image, built on a (K-1)*IFM+K deep pixel shift register.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low; clears shift register and state
//   clear      - synchronous soft frame restart (counters/flags only)
//   in_valid   - in_data holds a pixel
//   in_ready   - pixel accepted this cycle when in_valid is also high
//   in_data    - raster-order pixel
//   win_valid  - window_out holds a legal window
//   win_ready  - consumer takes the window
//   window_out - flattened window, tap (i,j) at [(i*K+j)*DATA_WIDTH +: DATA_WIDTH]
//   frame_done - one-cycle pulse after the last pixel of a frame is accepted

module window_fifo_gen #(
    parameter int DATA_WIDTH  = 28,
    parameter int IFM_SIZE    = 32,
    parameter int KERNAL_SIZE = 3,
    parameter int STRIDE      = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      clear,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_WIDTH-1:0]                     in_data,
    output logic                                      win_valid,
    input  logic                                      win_ready,
    output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_out,
    output logic                                      frame_done
);

    localparam int FIFO_SIZE = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE;
    localparam int CW = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] LAST = CW'(IFM_SIZE - 1);
    localparam logic [CW-1:0] KM1  = CW'(KERNAL_SIZE - 1);
    localparam logic [SW-1:0] SM1  = SW'(STRIDE - 1);

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_SIZE];
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    // Stride phase of the current col/row, measured from the first
    // position where a full window fits; avoids a modulo on the counters.
    logic [SW-1:0]         r_cph;
    logic [SW-1:0]         r_rph;
    logic                  r_win_valid;
    logic                  r_frame_done;

    logic                  w_accept;
    logic                  w_col_in;
    logic                  w_row_in;
    logic                  w_qual;
    logic                  w_last;
    logic [SW-1:0]         w_cph_nxt;
    logic [SW-1:0]         w_rph_nxt;

    assign in_ready   = !clear && (!r_win_valid || win_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_col_in   = (r_col >= KM1);
    assign w_row_in   = (r_row >= KM1);
    assign w_cph_nxt  = (r_cph == SM1) ? '0 : r_cph + SW'(1);
    assign w_rph_nxt  = (r_rph == SM1) ? '0 : r_rph + SW'(1);
    assign w_last     = (r_row == LAST) && (r_col == LAST);
    assign w_qual     = w_accept && w_col_in && w_row_in &&
                        (r_cph == '0) && (r_rph == '0);

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

    // Shift register: survives clear and frame boundaries, zeroed only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < FIFO_SIZE; k++) begin
                r_fifo[k] <= '0;
            end
        end else if (w_accept) begin
            r_fifo[0] <= in_data;
            for (int k = 1; k < FIFO_SIZE; k++) begin
                r_fifo[k] <= r_fifo[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_col        <= '0;
            r_row        <= '0;
            r_cph        <= '0;
            r_rph        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                if (r_col == LAST) begin
                    r_col <= '0;
                    r_cph <= '0;
                    if (r_row == LAST) begin
                        r_row <= '0;
                        r_rph <= '0;
                    end else begin
                        r_row <= r_row + CW'(1);
                        r_rph <= w_row_in ? w_rph_nxt : '0;
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                    r_cph <= w_col_in ? w_cph_nxt : '0;
                end
            end
            if (w_qual) begin
                r_win_valid <= 1'b1;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    // FIFO[0] is the newest pixel, i.e. the bottom-right tap.
    for (genvar gi = 0; gi < KERNAL_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < KERNAL_SIZE; gj++) begin : g_col
            assign window_out[(gi*KERNAL_SIZE+gj)*DATA_WIDTH +: DATA_WIDTH] =
                r_fifo[(KERNAL_SIZE-1-gi)*IFM_SIZE + (KERNAL_SIZE-1-gj)];
        end
    end

endmodule

// File: tb/tb_window_fifo_gen.sv
// Testbench for window_fifo_gen: two instances (stride 1 and 2) on a 5x5
// image with a 3x3 kernel, checked against a pixel-history reference model.

module tb_window_fifo_gen;

    localparam int DW  = 16;
    localparam int IFM = 5;
    localparam int K   = 3;
    localparam int WW  = K * K * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clr, iv, wr1, wr2;
    logic [DW-1:0] din;
    logic          rdy1, rdy2, wv1, wv2, fd1, fd2;
    logic [WW-1:0] wo1, wo2;

    window_fifo_gen #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .KERNAL_SIZE(K), .STRIDE(1)) dut1 (
        .clk(clk), .reset(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy1),
        .in_data(din), .win_valid(wv1), .win_ready(wr1), .window_out(wo1),
        .frame_done(fd1)
    );

    window_fifo_gen #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .KERNAL_SIZE(K), .STRIDE(2)) dut2 (
        .clk(clk), .reset(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy2),
        .in_data(din), .win_valid(wv2), .win_ready(wr2), .window_out(wo2),
        .frame_done(fd2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: every accepted pixel kept in order; a window is read
    // back from the history by its distance from the newest pixel.
    int            m_tot [2];
    int            m_n   [2];
    logic          m_wv  [2];
    logic          m_fd  [2];
    logic [WW-1:0] m_win [2];
    logic [DW-1:0] m_all [2][0:8191];

    typedef struct {
        logic [DW-1:0] d;
        logic          e_v1;
        logic          e_v2;
        logic          e_fd;
        logic [DW-1:0] e_t00;
        logic [DW-1:0] e_t02;
        logic [DW-1:0] e_t22;
    } vec_t;
    vec_t tbl [25];

    task automatic chk1(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkd(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] tap(logic [WW-1:0] w, int i, int j);
        return w[(i*K+j)*DW +: DW];
    endfunction

    task automatic model_edge(int u, logic wr);
        int r, c, s, off, idx;
        logic q;
        logic [WW-1:0] w;
        s = (u == 0) ? 1 : 2;
        if (!rst_n) begin
            m_tot[u] = 0; m_n[u] = 0; m_wv[u] = 1'b0; m_fd[u] = 1'b0;
        end else if (clr) begin
            m_n[u] = 0; m_wv[u] = 1'b0; m_fd[u] = 1'b0;
        end else if (iv && (!m_wv[u] || wr)) begin
            r = m_n[u] / IFM;
            c = m_n[u] % IFM;
            m_all[u][m_tot[u]] = din;
            m_tot[u]++;
            q = (r >= K-1) && (c >= K-1) &&
                ((r-K+1) % s == 0) && ((c-K+1) % s == 0);
            if (q) begin
                w = '0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        off = (K-1-i)*IFM + (K-1-j);
                        idx = m_tot[u] - 1 - off;
                        if (idx >= 0) w[(i*K+j)*DW +: DW] = m_all[u][idx];
                    end
                end
                m_win[u] = w;
                m_wv[u]  = 1'b1;
            end else if (wr) begin
                m_wv[u] = 1'b0;
            end
            m_fd[u] = (m_n[u] == IFM*IFM-1);
            m_n[u]  = (m_n[u] + 1) % (IFM*IFM);
        end else begin
            if (wr) m_wv[u] = 1'b0;
            m_fd[u] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, wr1);
        model_edge(1, wr2);
        #1;
        chk1("s1_in_ready", rdy1, !clr && (!m_wv[0] || wr1));
        chk1("s2_in_ready", rdy2, !clr && (!m_wv[1] || wr2));
        chk1("s1_win_valid", wv1, m_wv[0]);
        chk1("s2_win_valid", wv2, m_wv[1]);
        chk1("s1_frame_done", fd1, m_fd[0]);
        chk1("s2_frame_done", fd2, m_fd[1]);
        if (m_wv[0]) chkw("s1_window", wo1, m_win[0]);
        if (m_wv[1]) chkw("s2_window", wo2, m_win[1]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; iv = 1'b0; clr = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send(int v);
        iv  = 1'b1;
        din = DW'(v);
        step();
    endtask

    initial begin
        int cnt1, cnt2;
        rst_n = 1'b0; clr = 1'b0; iv = 1'b0; wr1 = 1'b1; wr2 = 1'b1; din = '0;

        for (int p = 1; p <= 25; p++) begin
            int r, c;
            r = (p-1) / IFM;
            c = (p-1) % IFM;
            tbl[p-1].d     = DW'(p);
            tbl[p-1].e_v1  = (r >= 2) && (c >= 2);
            tbl[p-1].e_v2  = (r == 2 || r == 4) && (c == 2 || c == 4);
            tbl[p-1].e_fd  = (p == 25);
            tbl[p-1].e_t00 = DW'(p - 12);
            tbl[p-1].e_t02 = DW'(p - 10);
            tbl[p-1].e_t22 = DW'(p);
        end

        repeat (3) step();
        chk1("reset_win_valid", wv1, 1'b0);
        chkw("reset_window_zero", wo1, '0);
        chk1("reset_frame_done", fd1, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("ready_after_reset", rdy1, 1'b1);

        cnt1 = 0;
        cnt2 = 0;
        for (int k = 0; k < 25; k++) begin
            iv  = 1'b1;
            din = tbl[k].d;
            step();
            chk1("tbl_v1", wv1, tbl[k].e_v1);
            chk1("tbl_v2", wv2, tbl[k].e_v2);
            chk1("tbl_fd", fd1, tbl[k].e_fd);
            chk1("tbl_fd2", fd2, tbl[k].e_fd);
            if (tbl[k].e_v1) begin
                chkd("tbl_tap00", tap(wo1, 0, 0), tbl[k].e_t00);
                chkd("tbl_tap02", tap(wo1, 0, 2), tbl[k].e_t02);
                chkd("tbl_tap22", tap(wo1, 2, 2), tbl[k].e_t22);
            end
            if (tbl[k].e_v2) chkd("tbl_s2_tap22", tap(wo2, 2, 2), tbl[k].d);
            cnt1 += int'(wv1);
            cnt2 += int'(wv2);
        end
        chkd("s1_window_count", DW'(cnt1), DW'(9));
        chkd("s2_window_count", DW'(cnt2), DW'(4));

        for (int p = 1; p <= 25; p++) begin
            send(p + 100);
            if (p == 12) chk1("f2_no_early_win", wv1, 1'b0);
            if (p == 13) begin
                chk1("f2_first_win", wv1, 1'b1);
                chkd("f2_tap00", tap(wo1, 0, 0), DW'(101));
            end
        end
        iv = 1'b0;
        step();

        do_reset();
        for (int p = 1; p <= 13; p++) send(p);
        wr1 = 1'b0;
        din = DW'(14);
        repeat (5) begin
            step();
            chk1("stall_in_ready", rdy1, 1'b0);
            chk1("stall_win_valid", wv1, 1'b1);
            chkd("stall_tap00", tap(wo1, 0, 0), DW'(1));
            chkd("stall_tap22", tap(wo1, 2, 2), DW'(13));
        end
        wr1 = 1'b1;
        step();
        chk1("resume_win_valid", wv1, 1'b1);
        chkd("resume_tap22", tap(wo1, 2, 2), DW'(14));
        chkd("resume_tap00", tap(wo1, 0, 0), DW'(2));
        iv = 1'b0;
        step();

        do_reset();
        for (int p = 1; p <= 8; p++) send(p);
        iv    = 1'b0;
        rst_n = 1'b0;
        step();
        chk1("midrst_win_valid", wv1, 1'b0);
        chkw("midrst_window_zero", wo1, '0);
        rst_n = 1'b1;
        step();
        for (int p = 1; p <= 13; p++) begin
            send(p);
            if (p == 12) chk1("midrst_no_early", wv1, 1'b0);
        end
        chk1("midrst_first_win", wv1, 1'b1);
        chkd("midrst_tap00", tap(wo1, 0, 0), DW'(1));
        chkd("midrst_tap22", tap(wo1, 2, 2), DW'(13));
        iv = 1'b0;
        step();

        do_reset();
        for (int p = 1; p <= 8; p++) send(p);
        clr = 1'b1;
        iv  = 1'b1;
        din = DW'(9);
        #1;
        chk1("clear_blocks_ready", rdy1, 1'b0);
        step();
        clr = 1'b0;
        for (int p = 1; p <= 13; p++) begin
            send(p + 50);
            if (p == 12) chk1("clear_no_early", wv1, 1'b0);
        end
        chk1("clear_first_win", wv1, 1'b1);
        chkd("clear_tap00", tap(wo1, 0, 0), DW'(51));
        chkd("clear_tap22", tap(wo1, 2, 2), DW'(63));
        iv = 1'b0;
        step();

        do_reset();
        for (int n = 0; n < 800; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            wr1 = ($urandom_range(0, 3) != 0);
            wr2 = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 80) == 0);
            din = DW'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_fifo_gen.md
WINDOW_FIFO_GEN -- requirements
Module: window_fifo_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 28: pixel width in bits.
REQ-002 SHALL have parameter IFM_SIZE, default 32: image row length and row count (square image).
REQ-003 SHALL have parameter KERNAL_SIZE, default 3: window edge, legal 2..IFM_SIZE.
REQ-004 SHALL have parameter STRIDE, default 1: window step, legal 1..KERNAL_SIZE.
REQ-005 SHALL have derived parameter FIFO_SIZE = (KERNAL_SIZE-1)*IFM_SIZE + KERNAL_SIZE: shift-register depth.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port clear, input, 1: synchronous soft frame restart, active-high.
REQ-009 SHALL have port in_valid, input, 1: in_data holds a pixel.
REQ-010 SHALL have port in_ready, output, 1: block accepts a pixel this cycle.
REQ-011 SHALL have port in_data, input, DATA_WIDTH: raster-order pixel.
REQ-012 SHALL have port win_valid, output, 1: window_out holds a legal window.
REQ-013 SHALL have port win_ready, input, 1: consumer takes the window.
REQ-014 SHALL have port window_out, output, KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH: flattened window.
REQ-015 SHALL have port frame_done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-016 SHALL define accept = in_valid && in_ready; in_ready = !clear && (!win_valid || win_ready), combinational.
REQ-017 SHALL on accept shift in_data into FIFO[0] and FIFO[k] into FIFO[k+1] for all k; no shift otherwise.
REQ-018 SHALL track the accepted pixel position with col and row counters, both 0..IFM_SIZE-1; col increments per accept, wraps to 0 at IFM_SIZE-1 and then increments row; row wraps to 0 after (IFM_SIZE-1, IFM_SIZE-1).
REQ-019 SHALL set win_valid next cycle on an accept at (row r, col c) iff r>=KERNAL_SIZE-1, c>=KERNAL_SIZE-1, (r-KERNAL_SIZE+1) mod STRIDE == 0 and (c-KERNAL_SIZE+1) mod STRIDE == 0; a window never spans a row boundary.
REQ-020 SHALL clear win_valid on a cycle with win_ready high and no qualifying accept; SHALL hold win_valid and window_out stable while win_valid && !win_ready.
REQ-021 SHALL drive tap (i,j), i = window row 0 (top)..KERNAL_SIZE-1, j = column 0 (left)..KERNAL_SIZE-1, from FIFO[(KERNAL_SIZE-1-i)*IFM_SIZE + (KERNAL_SIZE-1-j)], placed at window_out bits [(i*KERNAL_SIZE+j)*DATA_WIDTH +: DATA_WIDTH].
REQ-022 SHALL pulse frame_done for exactly one cycle, the cycle after the accept at (IFM_SIZE-1, IFM_SIZE-1), coincident with that pixel's win_valid when it qualifies.
REQ-023 SHALL keep shift-register contents across frames; validity for the new frame is governed solely by counters.
REQ-024 SHALL on clear zero col, row, win_valid, frame_done next cycle, leave shift contents unchanged, and accept no pixel that cycle.
REQ-025 SHALL pass data unmodified; no arithmetic on pixel values.

Reset
REQ-026 SHALL on reset low at a rising edge zero every FIFO entry, col, row, win_valid, frame_done; in_ready reads 1 the cycle after reset releases with win_valid 0.
REQ-027 SHALL give reset priority over clear and accept; reset mid-frame discards the partial frame.

Verification
REQ-028 K=3, IFM=5, STRIDE=1, pixel(r,c)=5r+c+1 streamed, win_ready=1 -> first win_valid the cycle after pixel 13, tap(0,0)=1, tap(0,2)=3, tap(2,2)=13; 9 windows per frame, none after cols 0-1 of any row.
REQ-029 Same stream, STRIDE=2 -> exactly 4 windows, bottom-right pixels 13,15,23,25; frame_done with window at 25.
REQ-030 K=3, IFM=5, win_ready held 0 after first window -> in_ready 0, window_out stays (1..13 window) for all stalled cycles, no pixel lost; resume gives next window bottom-right 14.
REQ-031 Two back-to-back frames, second frame pixel values +100 -> second frame first window tap(0,0)=101, no window at frame boundary containing mixed rows.
REQ-032 reset low after pixel 8 -> win_valid 0, window_out all zero; restart stream from pixel 1 -> first window after pixel 13 as in REQ-028.
REQ-033 clear high together with in_valid at pixel 9 -> pixel 9 not accepted, counters 0, next accepted pixel treated as (0,0).
